// File: rtl/watch_pkg.sv
// Shared state and field encodings for the watch setting control unit, the
// time datapath and the display mux. State codes double as o_sel field codes.
package watch_pkg;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;
    localparam logic [1:0] ST_SET_SEC  = 2'b11;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_HOUR = 2'b01;
    localparam logic [1:0] SEL_MIN  = 2'b10;
    localparam logic [1:0] SEL_SEC  = 2'b11;

    // Field order walked by the set button: hour -> min -> sec -> done.
    function automatic logic [1:0] next_field(input logic [1:0] st);
        logic [1:0] nxt;
        nxt = ST_IDLE;
        case (st)
            ST_IDLE:     nxt = ST_SET_HOUR;
            ST_SET_HOUR: nxt = ST_SET_MIN;
            ST_SET_MIN:  nxt = ST_SET_SEC;
            default:     nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/watch_set_timer.sv
// Inactivity timeout and blink generator for setting mode, both paced by the
// 1 kHz tick. Blink output is registered; timeout is a same-cycle flag.
module watch_set_timer #(
    parameter int TIMEOUT_TICKS = 5000,
    parameter int BLINK_HALF    = 500
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic clear_i,
    input  logic blink_restart_i,
    output logic timeout_o,
    output logic blink_o
);

    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] bl_cnt_q, bl_cnt_d;
    logic          blink_q, blink_d;
    logic          timeout;

    // Activity in the expiring cycle suppresses the timeout.
    assign timeout = tick_i && !clear_i && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (clear_i || timeout) begin
            to_cnt_d = '0;
        end else if (tick_i) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Restart (and the drop back to idle on timeout) shows the digits steadily.
    always_comb begin
        bl_cnt_d = bl_cnt_q;
        blink_d  = blink_q;
        if (blink_restart_i || timeout) begin
            bl_cnt_d = '0;
            blink_d  = 1'b1;
        end else if (tick_i) begin
            if (bl_cnt_q == BL_LAST) begin
                bl_cnt_d = '0;
                blink_d  = !blink_q;
            end else begin
                bl_cnt_d = bl_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            bl_cnt_q <= '0;
            blink_q  <= 1'b1;
        end else begin
            to_cnt_q <= to_cnt_d;
            bl_cnt_q <= bl_cnt_d;
            blink_q  <= blink_d;
        end
    end

    assign timeout_o = timeout;
    assign blink_o   = blink_q;

endmodule

// File: rtl/watch_set_cu.sv
// Watch time-setting control unit: walks hour/min/sec fields on the set button
// and turns up/down presses into one-cycle strobes for the selected field.
module watch_set_cu
    import watch_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 5000,
    parameter int BLINK_HALF    = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       i_tick,
    input  logic       i_btn_set,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic       o_hold,
    output logic [1:0] o_sel,
    output logic       o_inc,
    output logic       o_dec,
    output logic       o_blink
);

    logic [1:0] state_q, state_d;
    logic       hold_q, hold_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       active;
    logic       activity;
    logic       timeout;
    logic       adjust_ok;

    assign active    = (state_q != ST_IDLE);
    // Anything that restarts the timers: idle, abort, or any button press.
    assign activity  = !active || !mode || i_btn_set || i_btn_up || i_btn_down;
    assign adjust_ok = active && mode && !i_btn_set;

    watch_set_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .BLINK_HALF    (BLINK_HALF)
    ) u_timer (
        .clk_i           (clk),
        .rst_ni          (reset),
        .tick_i          (i_tick),
        .clear_i         (activity),
        .blink_restart_i (activity),
        .timeout_o       (timeout),
        .blink_o         (o_blink)
    );

    always_comb begin
        state_d = state_q;
        if (!mode) begin
            state_d = ST_IDLE;
        end else if (i_btn_set) begin
            state_d = next_field(state_q);
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        hold_d = (state_d != ST_IDLE);
        inc_d  = adjust_ok && i_btn_up && !i_btn_down;
        dec_d  = adjust_ok && i_btn_down && !i_btn_up;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    assign o_sel  = state_q;
    assign o_hold = hold_q;
    assign o_inc  = inc_q;
    assign o_dec  = dec_q;

endmodule

// File: tb/tb_watch_set_cu.sv
// Directed bench for watch_set_cu with short timeout/blink periods.
module tb_watch_set_cu;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       i_tick;
    logic       i_btn_set;
    logic       i_btn_up;
    logic       i_btn_down;
    logic       o_hold;
    logic [1:0] o_sel;
    logic       o_inc;
    logic       o_dec;
    logic       o_blink;

    int errors = 0;
    int checks = 0;

    watch_set_cu #(
        .TIMEOUT_TICKS (20),
        .BLINK_HALF    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .i_tick     (i_tick),
        .i_btn_set  (i_btn_set),
        .i_btn_up   (i_btn_up),
        .i_btn_down (i_btn_down),
        .o_hold     (o_hold),
        .o_sel      (o_sel),
        .o_inc      (o_inc),
        .o_dec      (o_dec),
        .o_blink    (o_blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic       set;
        logic       up;
        logic       down;
        logic       hold;
        logic [1:0] sel;
        logic       inc;
        logic       dec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic drive(input logic m, input logic t, input logic s,
                         input logic u, input logic d, input logic r);
        mode       = m;
        i_tick     = t;
        i_btn_set  = s;
        i_btn_up   = u;
        i_btn_down = d;
        reset      = r;
        @(posedge clk);
        #1;
        i_tick     = 1'b0;
        i_btn_set  = 1'b0;
        i_btn_up   = 1'b0;
        i_btn_down = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic check_all(input string tag, input int hold, input int sel,
                             input int inc, input int dec, input int blink);
        check({tag, ".hold"},  int'(o_hold),  hold);
        check({tag, ".sel"},   int'(o_sel),   sel);
        check({tag, ".inc"},   int'(o_inc),   inc);
        check({tag, ".dec"},   int'(o_dec),   dec);
        check({tag, ".blink"}, int'(o_blink), blink);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        mode = 0; i_tick = 0; i_btn_set = 0; i_btn_up = 0; i_btn_down = 0; reset = 0;

        //              mode set up dn  hold sel    inc dec
        vecs.push_back('{1'b0, 1, 0, 0, 1'b0, 2'd0, 0, 0}); // set ignored, mode=0
        vecs.push_back('{1'b1, 1, 0, 0, 1'b1, 2'd1, 0, 0}); // -> hour
        vecs.push_back('{1'b1, 1, 0, 0, 1'b1, 2'd2, 0, 0}); // -> min
        vecs.push_back('{1'b1, 1, 0, 0, 1'b1, 2'd3, 0, 0}); // -> sec
        vecs.push_back('{1'b1, 1, 0, 0, 1'b0, 2'd0, 0, 0}); // -> idle
        vecs.push_back('{1'b1, 1, 0, 0, 1'b1, 2'd1, 0, 0});
        vecs.push_back('{1'b1, 1, 0, 0, 1'b1, 2'd2, 0, 0}); // in min
        vecs.push_back('{1'b1, 0, 1, 0, 1'b1, 2'd2, 1, 0});
        vecs.push_back('{1'b1, 0, 0, 0, 1'b1, 2'd2, 0, 0});
        vecs.push_back('{1'b1, 0, 1, 0, 1'b1, 2'd2, 1, 0});
        vecs.push_back('{1'b1, 0, 1, 0, 1'b1, 2'd2, 1, 0});
        vecs.push_back('{1'b1, 0, 0, 1, 1'b1, 2'd2, 0, 1});
        vecs.push_back('{1'b1, 0, 0, 0, 1'b1, 2'd2, 0, 0});
        vecs.push_back('{1'b1, 0, 1, 1, 1'b1, 2'd2, 0, 0}); // up+down: no strobe
        vecs.push_back('{1'b0, 0, 1, 0, 1'b0, 2'd0, 0, 0}); // abort with up
        vecs.push_back('{1'b1, 0, 1, 0, 1'b0, 2'd0, 0, 0}); // idle ignores up
        vecs.push_back('{1'b1, 0, 0, 1, 1'b0, 2'd0, 0, 0}); // idle ignores down
        vecs.push_back('{1'b1, 1, 0, 0, 1'b1, 2'd1, 0, 0});
        vecs.push_back('{1'b1, 1, 0, 1, 1'b1, 2'd2, 0, 0}); // set beats down
        vecs.push_back('{1'b1, 1, 1, 0, 1'b1, 2'd3, 0, 0}); // set beats up
        vecs.push_back('{1'b1, 0, 0, 1, 1'b1, 2'd3, 0, 1});
        vecs.push_back('{1'b1, 0, 0, 0, 1'b1, 2'd3, 0, 0});

        do_reset();
        check_all("reset", 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mode, 1'b0, vecs[i].set, vecs[i].up, vecs[i].down, 1'b1);
            check_all($sformatf("vec%0d", i), int'(vecs[i].hold), int'(vecs[i].sel),
                      int'(vecs[i].inc), int'(vecs[i].dec), 1);
        end

        // Timeout: up on the expiring tick wins, then a full idle period expires.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("to.pre_sel", int'(o_sel), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_all("to.up_wins", 1, 1, 1, 0, 1);
        for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("to.tick19_sel", int'(o_sel), 1);
        check("to.tick19_hold", int'(o_hold), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("to.expired", 0, 0, 0, 0, 1);

        // Blink in seconds field, then restart on an up press while dark.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("bl.sel", int'(o_sel), 3);
        check("bl.entry", int'(o_blink), 1);
        for (int n = 1; n <= 14; n++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("bl.tick%0d", n), int'(o_blink), ((n / 4) % 2 == 0) ? 1 : 0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("bl.restart_blink", int'(o_blink), 1);
        check("bl.restart_inc", int'(o_inc), 1);
        for (int n = 1; n <= 4; n++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("bl.rtick%0d", n), int'(o_blink), (n == 4) ? 0 : 1);
        end
        check("bl.still_sec", int'(o_sel), 3);

        // Reset in the hour field overrides a simultaneous up press.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rs.hour", int'(o_sel), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all("rs.mid", 0, 0, 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("rs.after", 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/watch_set_cu.md
WATCH_SET_CU -- requirements
Module: watch_set_cu

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 5000, SHALL set the number of i_tick pulses without a button press before setting mode aborts.
REQ-002 Parameter BLINK_HALF, default 500, SHALL set the number of i_tick pulses per blink half-period.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 mode  input  1  SHALL select the watch view (1) or the stopwatch view (0).
REQ-006 i_tick  input  1  SHALL be a one-cycle 1 kHz timebase pulse.
REQ-007 i_btn_set  input  1  SHALL be a one-cycle, debounced pulse that enters setting or advances the field.
REQ-008 i_btn_up  input  1  SHALL be a one-cycle, debounced increment request.
REQ-009 i_btn_down  input  1  SHALL be a one-cycle, debounced decrement request.
REQ-010 o_hold  output  1  SHALL freeze the watch time counters while high.
REQ-011 o_sel  output  2  SHALL give the active field: 00 none, 01 hour, 10 min, 11 sec.
REQ-012 o_inc  output  1  SHALL be a one-cycle increment strobe for the field on o_sel.
REQ-013 o_dec  output  1  SHALL be a one-cycle decrement strobe for the field on o_sel.
REQ-014 o_blink  output  1  SHALL be the display-enable for the selected field (1 = digits visible).

Function
REQ-015 The FSM SHALL have four states: IDLE, SET_HOUR, SET_MIN and SET_SEC.
REQ-016 IDLE SHALL move to SET_HOUR on i_btn_set when mode=1; i_btn_set SHALL be ignored when mode=0.
REQ-017 i_btn_set SHALL advance the FSM SET_HOUR->SET_MIN->SET_SEC->IDLE.
REQ-018 Any non-IDLE state SHALL return to IDLE in the cycle after mode=0 is sampled (abort); no strobe SHALL be issued that cycle.
REQ-019 All outputs SHALL be registered, with 1-cycle latency from the input sample to the output.
REQ-020 o_hold SHALL be 1 and o_sel SHALL equal the field code in every non-IDLE state; in IDLE, o_hold=0 and o_sel=00.
REQ-021 In a non-IDLE state, i_btn_up alone SHALL produce o_inc=1 for exactly one cycle, and i_btn_down alone SHALL produce o_dec=1 for exactly one cycle.
REQ-022 Simultaneous up and down SHALL produce no strobe, but SHALL still count as activity.
REQ-023 i_btn_set SHALL take priority over up/down in the same cycle: the field advances and no strobe is issued.
REQ-024 In IDLE, up and down SHALL be ignored and o_inc=o_dec=0.
REQ-025 The timeout counter SHALL clear on state entry and on any button pulse, and SHALL increment on i_tick.
REQ-026 When the timeout counter is at TIMEOUT_TICKS-1 and i_tick arrives, the FSM SHALL go to IDLE.
REQ-027 A button pulse in the same cycle as the timeout SHALL win: the FSM stays, the counter clears, and the strobe is issued.
REQ-028 The blink counter SHALL count i_tick pulses and toggle o_blink every BLINK_HALF pulses, wrapping to 0.
REQ-029 On field entry or an up/down pulse, o_blink SHALL be forced to 1 and the blink counter cleared, so digits stay visible while adjusting.
REQ-030 In IDLE, o_blink SHALL be 1 and the blink counter SHALL be held at 0.
REQ-031 Counter widths SHALL be $clog2 of the parameter value, and the counters SHALL never exceed parameter-1.

Reset
REQ-032 When reset=0 at a clock edge: state=IDLE, o_hold=0, o_sel=00, o_inc=0, o_dec=0, o_blink=1, both counters=0.
REQ-033 Reset asserted mid-setting SHALL abort to IDLE without issuing a strobe; reset SHALL override every other input.

Structure
REQ-034 Package watch_pkg SHALL hold the state encoding and the field codes for o_sel (shared with the watch datapath and display mux).
REQ-035 Timeout and blink counting SHALL live in one sub-module, watch_set_timer (inputs: tick, clear, blink_restart; outputs: timeout, blink).
REQ-036 The top level SHALL contain the FSM and the strobe and output registers.

Verification (TIMEOUT_TICKS=20, BLINK_HALF=4 for sim)
REQ-037 reset=0 for 3 cycles, then 1 -> all outputs at their REQ-032 values; set with mode=0 -> state stays IDLE.
REQ-038 mode=1, set pulsed 4 times -> o_sel goes 01,10,11,00; o_hold=1 exactly while o_sel!=00.
REQ-039 In SET_MIN, up x3 then down x1 -> exactly 3 o_inc pulses then 1 o_dec pulse, each 1 cycle after its button; up+down together -> no strobe.
REQ-040 In SET_HOUR, 19 ticks then up on the tick-20 cycle -> stays SET_HOUR with o_inc=1; 20 further idle ticks -> IDLE, o_hold=0.
REQ-041 In SET_SEC with no buttons -> o_blink toggles every 4 ticks (1,0,1,...); an up pulse mid-low -> o_blink=1 next cycle and the period restarts.
REQ-042 Abort tests: mode->0 in SET_MIN with up in the same cycle -> IDLE, no o_inc; reset=0 in SET_HOUR -> REQ-032 values next cycle.
